// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: resolves load-use, ID-stage branch/jump and
// multi-cycle data-memory stalls, with saturating perf counters and a timeout flag.
module hazard_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rsaddr_i,
   input  logic [4:0]       id_rtaddr_i,
   input  logic             id_uses_rt_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rtaddr_i,
   input  logic             branch_taken_i,
   input  logic             jump_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ack_i,
   output logic             pc_write_o,
   output logic             if_id_write_o,
   output logic             if_id_flush_o,
   output logic             id_ex_bubble_o,
   output logic             hold_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

   typedef enum logic {RUN, MEM_WAIT} state_e;

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic mem_stall;
   logic load_use;

   assign load_use = ex_memread_i && (ex_rtaddr_i != 5'd0) &&
                     ((ex_rtaddr_i == id_rsaddr_i) ||
                      (id_uses_rt_i && (ex_rtaddr_i == id_rtaddr_i)));

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
      mem_stall  = 1'b0;

      unique case (state_q)
         RUN: begin
            if (dmem_req_i && !dmem_ack_i) begin
               mem_stall  = 1'b1;
               state_d    = MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (dmem_ack_i) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == TIMEOUT_VAL) begin
               // Access abandoned: release the pipeline and flag the error.
               err_d      = 1'b1;
               state_d    = RUN;
               wait_cnt_d = '0;
            end else begin
               mem_stall  = 1'b1;
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         default: state_d = RUN;
      endcase

      pc_write_o     = 1'b1;
      if_id_write_o  = 1'b1;
      if_id_flush_o  = 1'b0;
      id_ex_bubble_o = 1'b0;
      hold_o         = 1'b0;

      if (!rst_i) begin
         if (mem_stall) begin
            hold_o        = 1'b1;
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
         end else if (load_use) begin
            // ID instruction is held and re-evaluated, so a branch flush waits too.
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
         end else if (branch_taken_i || jump_i) begin
            if_id_flush_o = 1'b1;
         end
      end

      stall_cnt_d = stall_cnt_q;
      if ((hold_o || id_ex_bubble_o) && (stall_cnt_q != CNT_MAX))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);

      flush_cnt_d = flush_cnt_q;
      if (if_id_flush_o && (flush_cnt_q != CNT_MAX))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign err_o       = err_q;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: priority table in RUN plus hand-written
// multi-cycle sequences (load-use, branch, memory wait, timeout, reset, saturation).
module tb_hazard_ctrl;

   localparam int CNT_W       = 2;
   localparam int MEM_TIMEOUT = 4;

   logic             clk = 1'b0;
   logic             rst_i;
   logic [4:0]       id_rsaddr_i, id_rtaddr_i, ex_rtaddr_i;
   logic             id_uses_rt_i, ex_memread_i, branch_taken_i, jump_i;
   logic             dmem_req_i, dmem_ack_i;
   logic             pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, hold_o, err_o;
   logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .id_rsaddr_i    (id_rsaddr_i),
      .id_rtaddr_i    (id_rtaddr_i),
      .id_uses_rt_i   (id_uses_rt_i),
      .ex_memread_i   (ex_memread_i),
      .ex_rtaddr_i    (ex_rtaddr_i),
      .branch_taken_i (branch_taken_i),
      .jump_i         (jump_i),
      .dmem_req_i     (dmem_req_i),
      .dmem_ack_i     (dmem_ack_i),
      .pc_write_o     (pc_write_o),
      .if_id_write_o  (if_id_write_o),
      .if_id_flush_o  (if_id_flush_o),
      .id_ex_bubble_o (id_ex_bubble_o),
      .hold_o         (hold_o),
      .err_o          (err_o),
      .stall_cnt_o    (stall_cnt_o),
      .flush_cnt_o    (flush_cnt_o)
   );

   // {pc_write, if_id_write, if_id_flush, id_ex_bubble, hold}
   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       memread;
      logic [4:0] ex_rt;
      logic       br;
      logic       jmp;
      logic       req;
      logic       ack;
      logic [4:0] exp;
   } vec_t;

   vec_t vecs[14];

   function automatic logic [4:0] ctl();
      return {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, hold_o};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      id_rsaddr_i    = 5'd0;
      id_rtaddr_i    = 5'd0;
      id_uses_rt_i   = 1'b0;
      ex_memread_i   = 1'b0;
      ex_rtaddr_i    = 5'd0;
      branch_taken_i = 1'b0;
      jump_i         = 1'b0;
      dmem_req_i     = 1'b0;
      dmem_ack_i     = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_i = 1'b1;
      clear_inputs();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic set_load_use();
      ex_memread_i = 1'b1;
      ex_rtaddr_i  = 5'd2;
      id_rsaddr_i  = 5'd2;
   endtask

   initial begin
      rst_i = 1'b1;
      clear_inputs();

      //            rs     rt     ur    mr    ex_rt  br    jmp   req   ack   exp
      vecs[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'b11000};
      vecs[1]  = '{5'd2,  5'd0,  1'b0, 1'b1, 5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 5'b00010};
      vecs[2]  = '{5'd3,  5'd5,  1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 5'b00010};
      vecs[3]  = '{5'd3,  5'd5,  1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 5'b11000};
      vecs[4]  = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'b11000};
      vecs[5]  = '{5'd7,  5'd7,  1'b1, 1'b0, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 5'b11000};
      vecs[6]  = '{5'd1,  5'd4,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 5'b11100};
      vecs[7]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 5'b11100};
      vecs[8]  = '{5'd9,  5'd0,  1'b0, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 5'b00010};
      vecs[9]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'b00001};
      vecs[10] = '{5'd2,  5'd0,  1'b0, 1'b1, 5'd2,  1'b1, 1'b0, 1'b1, 1'b0, 5'b00001};
      vecs[11] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'b11000};
      vecs[12] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 5'b11100};
      vecs[13] = '{5'd31, 5'd0,  1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00010};

      // Reset state
      do_reset();
      #1;
      check("reset_ctl",   32'(ctl()),       32'h18);
      check("reset_err",   32'(err_o),       32'd0);
      check("reset_stall", 32'(stall_cnt_o), 32'd0);
      check("reset_flush", 32'(flush_cnt_o), 32'd0);

      // Priority table, each vector applied from a fresh RUN state
      for (int i = 0; i < 14; i++) begin
         do_reset();
         id_rsaddr_i    = vecs[i].rs;
         id_rtaddr_i    = vecs[i].rt;
         id_uses_rt_i   = vecs[i].uses_rt;
         ex_memread_i   = vecs[i].memread;
         ex_rtaddr_i    = vecs[i].ex_rt;
         branch_taken_i = vecs[i].br;
         jump_i         = vecs[i].jmp;
         dmem_req_i     = vecs[i].req;
         dmem_ack_i     = vecs[i].ack;
         #1;
         check($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].exp));
      end

      // Load-use: one stall cycle, then the load moves to MEM
      do_reset();
      set_load_use();
      #1;
      check("lu_stall_ctl", 32'(ctl()), 32'h02);
      tick();
      ex_memread_i = 1'b0;
      #1;
      check("lu_after_ctl", 32'(ctl()),       32'h18);
      check("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);

      // Branch flush, then branch concurrent with load-use
      do_reset();
      branch_taken_i = 1'b1;
      #1;
      check("br_flush", 32'(if_id_flush_o), 32'd1);
      tick();
      branch_taken_i = 1'b0;
      #1;
      check("br_flush_off", 32'(if_id_flush_o), 32'd0);
      check("br_flush_cnt", 32'(flush_cnt_o),   32'd1);
      branch_taken_i = 1'b1;
      set_load_use();
      #1;
      check("br_lu_ctl", 32'(ctl()), 32'h02);
      tick();
      clear_inputs();
      #1;
      check("br_lu_flush_cnt", 32'(flush_cnt_o), 32'd1);
      check("br_lu_stall_cnt", 32'(stall_cnt_o), 32'd1);

      // Memory wait: request at cycle 0, ack at cycle 3
      do_reset();
      dmem_req_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("mw_hold_c%0d", c), 32'(hold_o), 32'd1);
         tick();
      end
      dmem_ack_i = 1'b1;
      #1;
      check("mw_ack_ctl", 32'(ctl()), 32'h18);
      tick();
      clear_inputs();
      #1;
      check("mw_run_hold", 32'(hold_o),      32'd0);
      check("mw_stall_cnt", 32'(stall_cnt_o), 32'd3);
      check("mw_err",      32'(err_o),       32'd0);

      // Timeout: ack never arrives
      do_reset();
      dmem_req_i = 1'b1;
      for (int c = 0; c < MEM_TIMEOUT; c++) begin
         #1;
         check($sformatf("to_hold_c%0d", c), 32'(hold_o), 32'd1);
         tick();
      end
      #1;
      check("to_release_hold", 32'(hold_o), 32'd0);
      check("to_err_pre",      32'(err_o),  32'd0);
      tick();
      dmem_req_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("to_err_sticky%0d", c), 32'(err_o), 32'd1);
         check($sformatf("to_run_hold%0d", c),   32'(hold_o), 32'd0);
         tick();
      end
      do_reset();
      #1;
      check("to_err_cleared", 32'(err_o), 32'd0);

      // Reset pulsed during MEM_WAIT
      do_reset();
      dmem_req_i = 1'b1;
      tick();
      #1;
      check("rw_in_wait", 32'(hold_o), 32'd1);
      rst_i = 1'b1;
      #1;
      check("rw_rst_ctl", 32'(ctl()), 32'h18);
      tick();
      rst_i = 1'b0;
      clear_inputs();
      #1;
      check("rw_run_hold", 32'(hold_o),      32'd0);
      check("rw_stall",    32'(stall_cnt_o), 32'd0);
      check("rw_flush",    32'(flush_cnt_o), 32'd0);
      check("rw_err",      32'(err_o),       32'd0);

      // Saturation: six stall cycles and five flush cycles with 2-bit counters
      do_reset();
      set_load_use();
      for (int c = 1; c <= 6; c++) begin
         tick();
         #1;
         check($sformatf("sat_stall%0d", c), 32'(stall_cnt_o), 32'((c > 3) ? 3 : c));
      end
      clear_inputs();
      branch_taken_i = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         #1;
         check($sformatf("sat_flush%0d", c), 32'(flush_cnt_o), 32'((c > 3) ? 3 : c));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
